// File: rtl/roce_tx_segmenter_64.sv
// Splits RDMA WRITE work requests into MTU-sized RoCE packets: BTH/RETH/ImmDt headers plus passthrough payload.
// Define ROCE_TX_SEG_IMMDH_EN to enable WRITE-with-immediate opcodes and the ImmDt header.
module roce_tx_segmenter_64 #(
    parameter int unsigned MTU   = 1024,
    parameter logic [15:0] P_KEY = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_wr_valid,
    output logic        s_wr_ready,
    input  logic [31:0] s_wr_length,
    input  logic [63:0] s_wr_v_addr,
    input  logic [31:0] s_wr_r_key,
    input  logic [23:0] s_wr_dest_qp,
    input  logic [23:0] s_wr_psn,
    input  logic [31:0] s_wr_immd_data,
    input  logic        s_wr_immd_en,
    input  logic [63:0] s_axis_tdata,
    input  logic [7:0]  s_axis_tkeep,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    output logic        m_roce_bth_valid,
    input  logic        m_roce_bth_ready,
    output logic [7:0]  m_roce_bth_op_code,
    output logic [15:0] m_roce_bth_p_key,
    output logic [23:0] m_roce_bth_psn,
    output logic [23:0] m_roce_bth_dest_qp,
    output logic        m_roce_bth_ack_req,
    output logic        m_roce_reth_valid,
    input  logic        m_roce_reth_ready,
    output logic [63:0] m_roce_reth_v_addr,
    output logic [31:0] m_roce_reth_r_key,
    output logic [31:0] m_roce_reth_length,
    output logic        m_roce_immdh_valid,
    input  logic        m_roce_immdh_ready,
    output logic [31:0] m_roce_immdh_data,
    output logic [15:0] m_udp_length,
    output logic [63:0] m_roce_payload_axis_tdata,
    output logic [7:0]  m_roce_payload_axis_tkeep,
    output logic        m_roce_payload_axis_tvalid,
    input  logic        m_roce_payload_axis_tready,
    output logic        m_roce_payload_axis_tlast,
    output logic        m_roce_payload_axis_tuser,
    output logic        busy,
    output logic        error_early_termination,
    output logic        error_zero_length
);
    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DRAIN} state_t;

    localparam logic [31:0] MTU_W = 32'(MTU);

    state_t      state_q;
    logic        s_wr_ready_q, bth_valid_q, reth_valid_q, immdh_valid_q;
    logic        err_early_q, err_zero_q, last_pkt_q, ack_req_q, immd_en_q;
    logic [31:0] remaining_q, wr_len_q, r_key_q, immd_data_q;
    logic [63:0] v_addr_q;
    logic [23:0] psn_q, dest_qp_q;
    logic [12:0] pkt_len_q, byte_cnt_q;
    logic [7:0]  op_code_q;
    logic [15:0] udp_len_q;

    logic        imm_en_src, wr_accept, hdr_done, beat_xfer, pkt_end, early_end, load_hdr;
    logic        nxt_first, nxt_last, nxt_imm;
    logic [31:0] rem_after, nxt_rem;
    logic [12:0] nxt_len;
    logic [7:0]  nxt_op;
    logic [15:0] nxt_udp;

`ifdef ROCE_TX_SEG_IMMDH_EN
    assign imm_en_src         = (state_q == IDLE) ? s_wr_immd_en : immd_en_q;
    assign m_roce_immdh_valid = immdh_valid_q;
`else
    logic unused_immd;
    assign unused_immd        = s_wr_immd_en ^ immd_en_q ^ immdh_valid_q;
    assign imm_en_src         = 1'b0;
    assign m_roce_immdh_valid = 1'b0;
`endif

    // Header setup for the packet about to start: first packet comes from the WR itself,
    // later packets from what is left after the packet currently ending.
    assign rem_after = remaining_q - {19'd0, pkt_len_q};
    always_comb begin
        nxt_first = (state_q == IDLE);
        nxt_rem   = nxt_first ? s_wr_length : rem_after;
        nxt_last  = (nxt_rem <= MTU_W);
        nxt_len   = nxt_last ? nxt_rem[12:0] : MTU_W[12:0];
        nxt_imm   = nxt_last & imm_en_src;
        case ({nxt_first, nxt_last})
            2'b11:   nxt_op = nxt_imm ? 8'h0B : 8'h0A;
            2'b10:   nxt_op = 8'h06;
            2'b01:   nxt_op = nxt_imm ? 8'h09 : 8'h08;
            default: nxt_op = 8'h07;
        endcase
        nxt_udp = 16'd20 + (nxt_first ? 16'd16 : 16'd0) + (nxt_imm ? 16'd4 : 16'd0) + {3'b000, nxt_len};
    end

    // Payload is a zero-latency passthrough; DRAIN swallows the leftover input up to tlast.
    assign s_axis_tready              = ~rst & (((state_q == PAYLOAD) & m_roce_payload_axis_tready) | (state_q == DRAIN));
    assign m_roce_payload_axis_tvalid = ~rst & (state_q == PAYLOAD) & s_axis_tvalid;
    assign m_roce_payload_axis_tdata  = s_axis_tdata;
    assign m_roce_payload_axis_tkeep  = s_axis_tkeep;
    assign pkt_end                    = ({1'b0, byte_cnt_q} + 14'd8) >= {1'b0, pkt_len_q};
    assign early_end                  = s_axis_tlast & ~(pkt_end & last_pkt_q);
    assign m_roce_payload_axis_tlast  = pkt_end | s_axis_tlast;
    assign m_roce_payload_axis_tuser  = s_axis_tuser | early_end;
    assign beat_xfer                  = m_roce_payload_axis_tvalid & m_roce_payload_axis_tready;

    assign wr_accept = (state_q == IDLE) & s_wr_valid & s_wr_ready_q;
    assign hdr_done  = ~(bth_valid_q & ~m_roce_bth_ready) & ~(reth_valid_q & ~m_roce_reth_ready)
                     & ~(immdh_valid_q & ~m_roce_immdh_ready);
    assign load_hdr  = (wr_accept & (s_wr_length != 32'd0)) | (beat_xfer & ~early_end & pkt_end & ~last_pkt_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            s_wr_ready_q  <= 1'b0;
            bth_valid_q   <= 1'b0;
            reth_valid_q  <= 1'b0;
            immdh_valid_q <= 1'b0;
            err_early_q   <= 1'b0;
            err_zero_q    <= 1'b0;
        end else begin
            err_early_q <= 1'b0;
            err_zero_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    s_wr_ready_q <= 1'b1;
                    if (wr_accept) begin
                        remaining_q <= s_wr_length;
                        wr_len_q    <= s_wr_length;
                        psn_q       <= s_wr_psn;
                        v_addr_q    <= s_wr_v_addr;
                        r_key_q     <= s_wr_r_key;
                        dest_qp_q   <= s_wr_dest_qp;
                        immd_data_q <= s_wr_immd_data;
                        immd_en_q   <= s_wr_immd_en;
                        if (s_wr_length == 32'd0) begin
                            err_zero_q <= 1'b1;
                        end else begin
                            state_q      <= HDR;
                            s_wr_ready_q <= 1'b0;
                        end
                    end
                end
                HDR: begin
                    bth_valid_q   <= bth_valid_q & ~m_roce_bth_ready;
                    reth_valid_q  <= reth_valid_q & ~m_roce_reth_ready;
                    immdh_valid_q <= immdh_valid_q & ~m_roce_immdh_ready;
                    if (hdr_done) state_q <= PAYLOAD;
                end
                PAYLOAD: begin
                    if (beat_xfer) begin
                        byte_cnt_q <= byte_cnt_q + 13'd8;
                        if (early_end) begin
                            state_q      <= IDLE;
                            s_wr_ready_q <= 1'b1;
                            err_early_q  <= 1'b1;
                        end else if (pkt_end) begin
                            psn_q       <= psn_q + 24'd1;
                            remaining_q <= rem_after;
                            if (!last_pkt_q) begin
                                state_q <= HDR;
                            end else if (s_axis_tlast) begin
                                state_q      <= IDLE;
                                s_wr_ready_q <= 1'b1;
                            end else begin
                                state_q <= DRAIN;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (s_axis_tvalid && s_axis_tlast) begin
                        state_q      <= IDLE;
                        s_wr_ready_q <= 1'b1;
                        err_early_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (load_hdr) begin
                bth_valid_q   <= 1'b1;
                reth_valid_q  <= nxt_first;
                immdh_valid_q <= nxt_imm;
                op_code_q     <= nxt_op;
                ack_req_q     <= nxt_last;
                last_pkt_q    <= nxt_last;
                pkt_len_q     <= nxt_len;
                udp_len_q     <= nxt_udp;
                byte_cnt_q    <= 13'd0;
            end
        end
    end

    assign s_wr_ready              = s_wr_ready_q;
    assign busy                    = (state_q != IDLE);
    assign error_early_termination = err_early_q;
    assign error_zero_length       = err_zero_q;
    assign m_roce_bth_valid        = bth_valid_q;
    assign m_roce_bth_op_code      = op_code_q;
    assign m_roce_bth_p_key        = P_KEY;
    assign m_roce_bth_psn          = psn_q;
    assign m_roce_bth_dest_qp      = dest_qp_q;
    assign m_roce_bth_ack_req      = ack_req_q;
    assign m_roce_reth_valid       = reth_valid_q;
    assign m_roce_reth_v_addr      = v_addr_q;
    assign m_roce_reth_r_key       = r_key_q;
    assign m_roce_reth_length      = wr_len_q;
    assign m_roce_immdh_data       = immd_data_q;
    assign m_udp_length            = udp_len_q;
endmodule

// File: tb/tb_roce_tx_segmenter_64.sv
// Scoreboard bench for roce_tx_segmenter_64 (MTU=256): directed WRs, expected headers/beats queued, monitors compare.
module tb_roce_tx_segmenter_64;
    localparam int MTU = 256;
    localparam logic [63:0] VA   = 64'h1122_3344_5566_7788;
    localparam logic [31:0] RK   = 32'hAABB_CCDD;
    localparam logic [23:0] DQP  = 24'h123456;
    localparam logic [31:0] IMMD = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, s_wr_valid, s_wr_ready, s_wr_immd_en;
    logic [31:0] s_wr_length, s_wr_r_key, s_wr_immd_data;
    logic [63:0] s_wr_v_addr;
    logic [23:0] s_wr_dest_qp, s_wr_psn;
    logic [63:0] s_axis_tdata;
    logic [7:0]  s_axis_tkeep;
    logic        s_axis_tvalid, s_axis_tready, s_axis_tlast, s_axis_tuser;
    logic        bth_v, bth_rdy, bth_ack, reth_v, reth_rdy, immdh_v, immdh_rdy;
    logic [7:0]  bth_op;
    logic [15:0] bth_pkey, udp_len;
    logic [23:0] bth_psn, bth_dqp;
    logic [63:0] reth_va;
    logic [31:0] reth_rk, reth_len, immdh_data;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic        m_tvalid, m_tready, m_tlast, m_tuser;
    logic        busy, err_early, err_zero;

    roce_tx_segmenter_64 #(.MTU(MTU), .P_KEY(16'hFFFF)) dut (
        .clk(clk), .rst(rst),
        .s_wr_valid(s_wr_valid), .s_wr_ready(s_wr_ready), .s_wr_length(s_wr_length),
        .s_wr_v_addr(s_wr_v_addr), .s_wr_r_key(s_wr_r_key), .s_wr_dest_qp(s_wr_dest_qp),
        .s_wr_psn(s_wr_psn), .s_wr_immd_data(s_wr_immd_data), .s_wr_immd_en(s_wr_immd_en),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .m_roce_bth_valid(bth_v), .m_roce_bth_ready(bth_rdy), .m_roce_bth_op_code(bth_op),
        .m_roce_bth_p_key(bth_pkey), .m_roce_bth_psn(bth_psn), .m_roce_bth_dest_qp(bth_dqp),
        .m_roce_bth_ack_req(bth_ack),
        .m_roce_reth_valid(reth_v), .m_roce_reth_ready(reth_rdy), .m_roce_reth_v_addr(reth_va),
        .m_roce_reth_r_key(reth_rk), .m_roce_reth_length(reth_len),
        .m_roce_immdh_valid(immdh_v), .m_roce_immdh_ready(immdh_rdy), .m_roce_immdh_data(immdh_data),
        .m_udp_length(udp_len),
        .m_roce_payload_axis_tdata(m_tdata), .m_roce_payload_axis_tkeep(m_tkeep),
        .m_roce_payload_axis_tvalid(m_tvalid), .m_roce_payload_axis_tready(m_tready),
        .m_roce_payload_axis_tlast(m_tlast), .m_roce_payload_axis_tuser(m_tuser),
        .busy(busy), .error_early_termination(err_early), .error_zero_length(err_zero)
    );

    typedef struct packed {logic [7:0] op; logic [23:0] psn; logic ack; logic [15:0] udp; logic reth; logic imm;} bth_exp_t;
    typedef struct packed {logic [63:0] va; logic [31:0] rk; logic [31:0] len;} reth_exp_t;
    typedef struct packed {logic [63:0] data; logic [7:0] keep; logic last; logic user;} beat_exp_t;

    bth_exp_t  bth_q[$];
    reth_exp_t reth_q[$];
    logic [31:0] imm_q[$];
    beat_exp_t beat_q[$];

    int total = 0;
    int bad   = 0;
    int n_early = 0;
    int n_zero  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- ready generators ----------------
    bit bth_delay = 0;
    bit tr_pat    = 0;
    int bth_wait  = 0;
    int pidx      = 0;
    bit pat [5]   = '{1, 1, 0, 0, 1};

    always @(posedge clk) begin
        #1;
        if (bth_delay) begin
            bth_wait = bth_v ? bth_wait + 1 : 0;
            bth_rdy  = bth_v && (bth_wait > 5);
        end else begin
            bth_rdy = 1'b1;
        end
        if (tr_pat) begin
            m_tready = pat[pidx];
            pidx     = (pidx + 1) % 5;
        end else begin
            m_tready = 1'b1;
        end
    end

    // ---------------- monitors ----------------
    bth_exp_t  be;
    reth_exp_t re;
    beat_exp_t pe;
    logic [31:0] ie;
    logic        prev_bth_v = 1'b0;
    logic        held = 1'b0;
    logic [48:0] snap;
    logic [15:0] cur_udp = 16'd0;

    always @(negedge clk) begin
        if (rst) begin
            prev_bth_v = 1'b0;
            held       = 1'b0;
        end else begin
            if (bth_v && !prev_bth_v) begin
                if (bth_q.size() == 0) chk("bth_unexpected", {63'd0, bth_v}, 64'd0);
                else begin
                    chk("reth_rise_with_bth", {63'd0, reth_v}, {63'd0, bth_q[0].reth});
                    chk("immdh_rise_with_bth", {63'd0, immdh_v}, {63'd0, bth_q[0].imm});
                end
            end
            if (held && bth_v) chk("bth_held_stable", {15'd0, bth_op, bth_psn, bth_ack, udp_len}, {15'd0, snap});
            if (bth_v && bth_rdy && bth_q.size() > 0) begin
                be = bth_q.pop_front();
                chk("bth_opcode", {56'd0, bth_op}, {56'd0, be.op});
                chk("bth_psn", {40'd0, bth_psn}, {40'd0, be.psn});
                chk("bth_ack_req", {63'd0, bth_ack}, {63'd0, be.ack});
                chk("bth_p_key", {48'd0, bth_pkey}, 64'hFFFF);
                chk("bth_dest_qp", {40'd0, bth_dqp}, {40'd0, DQP});
                chk("udp_length", {48'd0, udp_len}, {48'd0, be.udp});
                cur_udp = be.udp;
            end
            held       = bth_v && !bth_rdy;
            snap       = {bth_op, bth_psn, bth_ack, udp_len};
            prev_bth_v = bth_v;

            if (reth_v && reth_rdy) begin
                if (reth_q.size() == 0) chk("reth_unexpected", {63'd0, reth_v}, 64'd0);
                else begin
                    re = reth_q.pop_front();
                    chk("reth_v_addr", reth_va, re.va);
                    chk("reth_rkey_len", {reth_rk, reth_len}, {re.rk, re.len});
                end
            end
            if (immdh_v && immdh_rdy) begin
                if (imm_q.size() == 0) chk("immdh_unexpected", {63'd0, immdh_v}, 64'd0);
                else begin
                    ie = imm_q.pop_front();
                    chk("immdh_data", {32'd0, immdh_data}, {32'd0, ie});
                end
            end
            if (m_tvalid && m_tready) begin
                if (beat_q.size() == 0) chk("beat_unexpected", {63'd0, m_tvalid}, 64'd0);
                else begin
                    pe = beat_q.pop_front();
                    chk("beat_data", m_tdata, pe.data);
                    chk("beat_keep_last_user", {54'd0, m_tkeep, m_tlast, m_tuser}, {54'd0, pe.keep, pe.last, pe.user});
                    chk("udp_length_hold", {48'd0, udp_len}, {48'd0, cur_udp});
                end
            end
            if (err_early) n_early++;
            if (err_zero)  n_zero++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_bth(input logic [7:0] op, input logic [23:0] psn, input logic ack,
                            input logic [15:0] udp, input logic reth, input logic imm);
        bth_q.push_back('{op: op, psn: psn, ack: ack, udp: udp, reth: reth, imm: imm});
    endtask

    task automatic push_reth(input logic [31:0] len);
        reth_q.push_back('{va: VA, rk: RK, len: len});
    endtask

    task automatic push_beats(input int tag, input int start, input int n, input logic [7:0] last_keep,
                              input bit last_flag, input bit user_last, input int user_at);
        for (int j = 0; j < n; j++) begin
            int idx = start + j;
            beat_q.push_back('{data: {32'(tag), 32'(idx)},
                               keep: (j == n - 1) ? last_keep : 8'hFF,
                               last: (j == n - 1) && last_flag,
                               user: ((j == n - 1) && user_last) || (idx == user_at)});
        end
    endtask

    task automatic issue_wr(input logic [31:0] len, input logic [23:0] psn, input logic imm_en);
        int w = 0;
        s_wr_length = len; s_wr_psn = psn; s_wr_immd_en = imm_en;
        s_wr_v_addr = VA; s_wr_r_key = RK; s_wr_dest_qp = DQP; s_wr_immd_data = IMMD;
        s_wr_valid = 1'b1;
        @(negedge clk);
        while (!s_wr_ready && w < 2000) begin w++; @(negedge clk); end
        if (w >= 2000) chk("wr_ready_timeout", {63'd0, s_wr_ready}, 64'd1);
        @(posedge clk); #1;
        s_wr_valid = 1'b0;
    endtask

    task automatic drive_beats(input int tag, input int n, input logic [7:0] last_keep,
                               input bit with_last, input int user_at);
        for (int i = 0; i < n; i++) begin
            int w = 0;
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = {32'(tag), 32'(i)};
            s_axis_tkeep  = (i == n - 1) ? last_keep : 8'hFF;
            s_axis_tlast  = with_last && (i == n - 1);
            s_axis_tuser  = (i == user_at);
            @(negedge clk);
            while (!s_axis_tready && w < 2000) begin w++; @(negedge clk); end
            if (w >= 2000) begin
                chk("payload_tready_timeout", {63'd0, s_axis_tready}, 64'd1);
                s_axis_tvalid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int w = 0;
        @(negedge clk);
        while ((busy || bth_q.size() + reth_q.size() + imm_q.size() + beat_q.size() != 0) && w < 3000) begin
            w++; @(negedge clk);
        end
        chk(name, 64'(bth_q.size() + reth_q.size() + imm_q.size() + beat_q.size()), 64'd0);
        chk("busy_idle_after_wr", {63'd0, busy}, 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int e0;
        rst = 1'b1; s_wr_valid = 1'b0; s_wr_length = '0; s_wr_psn = '0; s_wr_immd_en = 1'b0;
        s_wr_v_addr = '0; s_wr_r_key = '0; s_wr_dest_qp = '0; s_wr_immd_data = '0;
        s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
        reth_rdy = 1'b1; immdh_rdy = 1'b1; bth_rdy = 1'b1; m_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", {57'd0, s_wr_ready, s_axis_tready, bth_v, reth_v, immdh_v, busy, err_early | err_zero}, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("wr_ready_after_rst", {63'd0, s_wr_ready}, 64'd1);

        // 600 bytes over MTU 256: FIRST/MIDDLE/LAST, input tuser on beat 3 passes through
        push_bth(8'h06, 24'd200, 1'b0, 16'd292, 1'b1, 1'b0);
        push_bth(8'h07, 24'd201, 1'b0, 16'd276, 1'b0, 1'b0);
        push_bth(8'h08, 24'd202, 1'b1, 16'd108, 1'b0, 1'b0);
        push_reth(32'd600);
        push_beats(1, 0, 32, 8'hFF, 1, 0, 3);
        push_beats(1, 32, 32, 8'hFF, 1, 0, -1);
        push_beats(1, 64, 11, 8'hFF, 1, 0, -1);
        e0 = n_early;
        fork
            issue_wr(32'd600, 24'd200, 1'b1 ^ 1'b1);
            drive_beats(1, 75, 8'hFF, 1, 3);
        join
        wait_done("t1_scoreboard_empty");
        chk("t1_no_early_error", 64'(n_early - e0), 64'd0);

        // 92-byte ONLY packet with immediate request; partial keep on the final beat
`ifdef ROCE_TX_SEG_IMMDH_EN
        push_bth(8'h0B, 24'd5, 1'b1, 16'd132, 1'b1, 1'b1);
        imm_q.push_back(IMMD);
`else
        push_bth(8'h0A, 24'd5, 1'b1, 16'd128, 1'b1, 1'b0);
`endif
        push_reth(32'd92);
        push_beats(2, 0, 12, 8'h0F, 1, 0, -1);
        fork
            issue_wr(32'd92, 24'd5, 1'b1);
            drive_beats(2, 12, 8'h0F, 1, -1);
        join
        wait_done("t2_scoreboard_empty");

        // PSN wrap
        push_bth(8'h06, 24'hFFFFFF, 1'b0, 16'd292, 1'b1, 1'b0);
        push_bth(8'h08, 24'h000000, 1'b1, 16'd276, 1'b0, 1'b0);
        push_reth(32'd512);
        push_beats(3, 0, 32, 8'hFF, 1, 0, -1);
        push_beats(3, 32, 32, 8'hFF, 1, 0, -1);
        fork
            issue_wr(32'd512, 24'hFFFFFF, 1'b0);
            drive_beats(3, 64, 8'hFF, 1, -1);
        join
        wait_done("t3_scoreboard_empty");

        // Backpressure: payload ready 1,1,0,0,1 and BTH ready held off
        bth_delay = 1; tr_pat = 1;
        push_bth(8'h06, 24'd10, 1'b0, 16'd292, 1'b1, 1'b0);
        push_bth(8'h08, 24'd11, 1'b1, 16'd276, 1'b0, 1'b0);
        push_reth(32'd512);
        push_beats(4, 0, 32, 8'hFF, 1, 0, -1);
        push_beats(4, 32, 32, 8'hFF, 1, 0, -1);
        fork
            issue_wr(32'd512, 24'd10, 1'b0);
            drive_beats(4, 64, 8'hFF, 1, -1);
        join
        wait_done("t4_scoreboard_empty");
        bth_delay = 0; tr_pat = 0;

        // Early input tlast at byte 300 of a 600-byte WR
        push_bth(8'h06, 24'd300, 1'b0, 16'd292, 1'b1, 1'b0);
        push_bth(8'h07, 24'd301, 1'b0, 16'd276, 1'b0, 1'b0);
        push_reth(32'd600);
        push_beats(5, 0, 32, 8'hFF, 1, 0, -1);
        push_beats(5, 32, 6, 8'h0F, 1, 1, -1);
        e0 = n_early;
        fork
            issue_wr(32'd600, 24'd300, 1'b0);
            drive_beats(5, 38, 8'h0F, 1, -1);
        join
        wait_done("t5_scoreboard_empty");
        chk("t5_early_pulses", 64'(n_early - e0), 64'd1);

        // Input longer than the WR: excess beats drained
        push_bth(8'h0A, 24'd7, 1'b1, 16'd100, 1'b1, 1'b0);
        push_reth(32'd64);
        push_beats(6, 0, 8, 8'hFF, 1, 0, -1);
        e0 = n_early;
        fork
            issue_wr(32'd64, 24'd7, 1'b0);
            drive_beats(6, 10, 8'hFF, 1, -1);
        join
        wait_done("t6_scoreboard_empty");
        chk("t6_drain_pulses", 64'(n_early - e0), 64'd1);

        // Zero-length WR
        e0 = n_zero;
        issue_wr(32'd0, 24'd9, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("t7_zero_pulses", 64'(n_zero - e0), 64'd1);
        chk("t7_no_header", {62'd0, bth_v, busy}, 64'd0);

        // Reset in the middle of PAYLOAD
        push_bth(8'h06, 24'd50, 1'b0, 16'd292, 1'b1, 1'b0);
        push_reth(32'd512);
        push_beats(8, 0, 10, 8'hFF, 0, 0, -1);
        fork
            issue_wr(32'd512, 24'd50, 1'b0);
            drive_beats(8, 10, 8'hFF, 0, -1);
        join
        chk("t8_busy_mid_payload", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t8_rst_outputs", {57'd0, bth_v, reth_v, immdh_v, m_tvalid, s_wr_ready, s_axis_tready, busy}, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("t8_wr_ready_rise", {63'd0, s_wr_ready}, 64'd1);
        chk("t8_scoreboard_empty", 64'(bth_q.size() + reth_q.size() + beat_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
